led_frame_scheduler: RTL
========================

# led_frame_scheduler

Frame-rate controller for the LED strip path: on every frame tick it picks one of several pattern/visualizer sources by round-robin arbitration, reads that source's colour for every LED in order, and feeds the strip streamer's write port (`rgb`/`new_rgb`) exactly `NUM_LEDS` pixels per frame. It sits between the visualizer sources and the strip streamer, and it keeps the streamer's free-running, reset-free write pointer aligned.

## Interface
- `NUM_LEDS`, 72: pixels per frame; must match the streamer's write wrap (0..71).
- `NUM_SRC`, 4: number of requesting sources (2..8).
- `FRAME_TICKS`, 400000: frame period in clocks (4 ms at 100 MHz); must be ≥ 2*NUM_LEDS+4.

Ports:
- `clk_100mhz` in 1: system clock.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `enable` in 1: when low, new frames are not started.
- `src_req` in NUM_SRC: level request per source.
- `src_rgb` in 24*NUM_SRC: per-source pixel {R,G,B}, valid 1 cycle after `src_rd`.
- `src_grant` out NUM_SRC: one-hot owner of the current frame.
- `src_rd` out 1: pixel read strobe to the granted source.
- `src_led_idx` out 7: pixel index being read.
- `rgb` out 24: pixel to the streamer.
- `new_rgb` out 1: one-cycle write strobe to the streamer.
- `frame_done` out 1: one-cycle pulse after the last pixel write.
- `busy` out 1: high while a frame is in progress.
- `overrun` out 1: sticky; set when a tick arrives while busy.

## Operation
- Frame timer: the counter runs 0..FRAME_TICKS-1 and wraps. `tick` fires on the wrap cycle. It runs whenever out of reset, independent of `enable`.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: on `tick` with `enable`=1 and `|src_req`:
    - Register the grant from the round-robin pointer (search starts at last winner + 1).
    - Set idx=0 and go to READ.
    - Otherwise stay in IDLE.
  - READ: `src_rd`=1 and `src_led_idx`=idx, both Moore outputs. Go to WRITE.
  - WRITE:
    - Register `rgb` <= the granted source's slice of `src_rgb`, and `new_rgb` <= 1.
    - If idx==NUM_LEDS-1, go to DONE. Otherwise increment idx and go to READ.
  - DONE:
    - `frame_done`=1.
    - Update the round-robin pointer to the granted source.
    - Clear `src_grant` at the next edge and go to IDLE.
- `busy` = state != IDLE.
- `src_req` or `enable` dropping mid-frame: ignored. The frame always completes all NUM_LEDS writes to preserve streamer alignment.
- Simultaneous requests: the round-robin pointer decides. With a single requester, it wins every frame.
- `tick` while busy: the tick is dropped and `overrun` is set. `overrun` clears only on reset.
- idx width is 7 bits. No wrap occurs inside a frame.
- Reset values:
  - All outputs 0.
  - State IDLE, idx 0, timer 0.
  - Round-robin pointer = NUM_SRC-1, so source 0 has first priority.
- `rst_n` mid-frame: aborts immediately with outputs 0. The streamer's write pointer is reset-free, so `rst_n` is a power-up reset only and the system applies it before the streamer's first write.

## Timing
- Tick at cycle t (IDLE): `src_grant` and `busy` are visible at t+1, and READ occupies t+1.
- Pixel k: `src_rd` at t+1+2k; `new_rgb`/`rgb` at t+3+2k.
- Last `new_rgb` (k=71) at t+145. `frame_done` at t+145. `src_grant`/`busy` low at t+146.
- Throughput: 1 pixel per 2 cycles; a frame occupies 146 cycles.
- Sources must have 1-cycle read latency, with `src_rgb` stable during the WRITE cycle.

## Configuration
- `LED_SCHED_BLANK_EN` defined:
  - A tick that finds no request, or `enable`=0, still runs a full frame with `src_grant`=0 and `src_rd`=0.
  - It writes `rgb`=24'h000000 for all NUM_LEDS pixels (strip goes dark), with identical timing.
  - The round-robin pointer is unchanged.
- `LED_SCHED_BLANK_EN` undefined: such ticks are ignored and the strip holds its last frame.

## Structure
- Shared package `led_pkg`:
  - `rgb_t` (24-bit packed R/G/B).
  - `LED_COUNT` constant (72), used by both this block and the streamer.
  - `led_sched_state_e` enum.
- Sub-module `rr_arbiter` (parameter N): inputs are the request vector and pointer; output is the one-hot grant, combinational.
- Everything else is in this module.

## Test plan
- Single source, FRAME_TICKS=400: `src_req`=4'b0001, with source 0 returning `{idx,idx,idx}`. Expect 72 `new_rgb` pulses with `rgb`=0x000000..0x474747 in order, spaced 2 cycles apart, then `frame_done` at t+145.
- Round-robin: `src_req`=4'b1011 held for 4 frames. Expect grants 0001, 0010, 1000, 0001.
- Overrun: FRAME_TICKS=100. Expect `overrun`=1 after the second tick, and still exactly 72 writes per started frame.
- Mid-frame drop: deassert `src_req` and `enable` at pixel 10. Expect all 72 writes to complete and no new frame to start.
- Blank (macro defined): no requests. Expect 72 writes of 0x000000 per tick with `src_rd` never high. With the macro undefined, expect zero writes.
- Async reset at pixel 30: all outputs go 0 immediately. After release, the first frame grants source 0.

Source files
------------

// File: rtl/led_pkg.sv
// ============================================================================
// Package  : led_pkg
// Brief    : Shared pixel type, strip length and scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam int LED_COUNT = 72;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } led_sched_state_e;

endpackage : led_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick; search starts one past i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant
);

    localparam int PW = $clog2(N);

    int            w_pos;
    logic [PW-1:0] w_sel;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int i = 1; i <= N; i++) begin
            w_pos = (int'(i_ptr) + i) % N;
            w_sel = PW'(w_pos);
            if (!w_found && i_req[w_sel]) begin
                o_grant[w_sel] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/led_frame_scheduler.sv
// ============================================================================
// Module   : led_frame_scheduler
// Brief    : Per-frame round-robin source pick, streams NUM_LEDS pixels into
//            the strip streamer write port at one pixel per two clocks.
// Options  : LED_SCHED_BLANK_EN - ticks with no eligible source run a dark frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int NUM_LEDS    = LED_COUNT,
    parameter int NUM_SRC     = 4,
    parameter int FRAME_TICKS = 400000
) (
    input  logic                  clk_100mhz,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [24*NUM_SRC-1:0] src_rgb,
    output logic [NUM_SRC-1:0]    src_grant,
    output logic                  src_rd,
    output logic [6:0]            src_led_idx,
    output logic [23:0]           rgb,
    output logic                  new_rgb,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overrun
);

    localparam int             TW        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int             PW        = $clog2(NUM_SRC);
    localparam logic [TW-1:0]  TICK_LAST = TW'(FRAME_TICKS - 1);
    localparam logic [6:0]     IDX_LAST  = 7'(NUM_LEDS - 1);

    led_sched_state_e    state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [6:0]          idx_q, idx_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic                rd_q, rd_d;
    rgb_t                rgb_q, rgb_d;
    logic                new_rgb_q, new_rgb_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    logic                w_tick;
    logic                w_start;
    logic [NUM_SRC-1:0]  w_arb_grant;
    logic [NUM_SRC-1:0]  w_start_grant;
    logic [23:0]         w_sel_rgb;
    logic [PW-1:0]       w_grant_idx;

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_arb (
        .i_req   (src_req),
        .i_ptr   (ptr_q),
        .o_grant (w_arb_grant)
    );

    assign w_tick = (timer_q == TICK_LAST);

`ifdef LED_SCHED_BLANK_EN
    // Every tick starts a frame; with no eligible source the grant is empty and pixels read as black.
    assign w_start       = w_tick;
    assign w_start_grant = enable ? w_arb_grant : '0;
`else
    assign w_start       = w_tick && enable && (|src_req);
    assign w_start_grant = w_arb_grant;
`endif

    always_comb begin
        w_sel_rgb   = '0;
        w_grant_idx = ptr_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                w_sel_rgb   = w_sel_rgb | src_rgb[24*i +: 24];
                w_grant_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = w_tick ? '0 : timer_q + TW'(1);
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        rgb_d     = rgb_q;
        new_rgb_d = 1'b0;
        overrun_d = overrun_q | (w_tick && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    grant_d = w_start_grant;
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                rgb_d     = rgb_t'(w_sel_rgb);
                new_rgb_d = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                // An empty (blank) grant leaves the pointer where it was.
                ptr_d   = w_grant_idx;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rd_d   = (state_d == ST_READ) && (|grant_d);
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= PW'(NUM_SRC - 1);
            grant_q   <= '0;
            rd_q      <= 1'b0;
            rgb_q     <= '0;
            new_rgb_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            rd_q      <= rd_d;
            rgb_q     <= rgb_d;
            new_rgb_q <= new_rgb_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign src_grant   = grant_q;
    assign src_rd      = rd_q;
    assign src_led_idx = idx_q;
    assign rgb         = rgb_q;
    assign new_rgb     = new_rgb_q;
    assign frame_done  = done_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule : led_frame_scheduler

`default_nettype wire
